// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write-back paths, write-first bypass
// and a busy scoreboard for outstanding long-latency writes.
module regfile_mp_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NREAD = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  wb0_en,
  input  logic [AW-1:0]         wb0_addr,
  input  logic [XLEN-1:0]       wb0_data,
  input  logic                  wb1_en,
  input  logic [AW-1:0]         wb1_addr,
  input  logic [XLEN-1:0]       wb1_data,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_addr,
  output logic                  any_busy
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            wb0_we;
  logic            wb1_we;
  logic            iss_we;

  function automatic logic is_zr(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wb0_we = wb0_en && !is_zr(wb0_addr);
  assign wb1_we = wb1_en && !is_zr(wb1_addr);
  assign iss_we = issue_en && !is_zr(issue_addr);

  // wb0 is younger, so its write lands last on a same-address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      if (wb1_we) regs_q[wb1_addr] <= wb1_data;
      if (wb0_we) regs_q[wb0_addr] <= wb0_data;
    end
  end

  // a reissue to a completing destination keeps it pending
  always_comb begin
    busy_d = busy_q;
    if (wb1_we) busy_d[wb1_addr] = 1'b0;
    if (iss_we) busy_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign any_busy = |busy_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            wb1_hit;

    assign a       = raddr[i*AW +: AW];
    assign wb1_hit = wb1_en && (wb1_addr == a);

    always_comb begin
      d = regs_q[a];
      if (rst || is_zr(a)) begin
        d = '0;
      end else if (wb0_en && (wb0_addr == a)) begin
        d = wb0_data;
      end else if (wb1_hit) begin
        d = wb1_data;
      end
    end

    assign rdata[i*XLEN +: XLEN] = d;
    assign rbusy[i] = busy_q[a] && !wb1_hit && !is_zr(a);
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised successor to the single-write, two-read register file. It provides NREAD combinational read ports and two write-back ports: wb0 for the ALU/short path and wb1 for the load/long-latency path. Each read port has write-first bypass. A per-register busy scoreboard tracks outstanding long-latency writes and reports per-port hazards to the decode stage, which uses them to stall.

Parameters:
XLEN, 32, data width of each register.
NREG, 32, number of registers; power of two, at least 2. AW = clog2(NREG) is derived locally.
NREAD, 2, number of read ports, 1..4.
ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and issues.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
raddr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
rdata  out  NREAD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
rbusy  out  NREAD  port i's source has an outstanding long-latency write.
wb0_en  in  1  short-path write enable.
wb0_addr  in  AW  short-path destination.
wb0_data  in  XLEN  short-path data.
wb1_en  in  1  long-path write enable; also clears the busy bit.
wb1_addr  in  AW  long-path destination.
wb1_data  in  XLEN  long-path data.
issue_en  in  1  a long-latency instruction issues this cycle.
issue_addr  in  AW  its destination; the busy bit is set.
any_busy  out  1  OR of all busy bits.

Behaviour:
- Reset (async, rst=1): all registers are 0 and all busy bits are 0. Consequences while in or just after reset:
  - rdata reads 0 on every port.
  - rbusy=0 and any_busy=0.
  - Writes and issues are ignored while rst=1.
- Storage:
  - Register writes happen on the rising clk edge.
  - wb0 and wb1 may write different addresses in the same cycle.
  - If wb0_en and wb1_en target the same address, wb0_data is stored (wb0 is younger in program order).
- Read (combinational, zero latency). Priority for port i:
  1. Address 0 with ZERO_REG=1 returns 0.
  2. Otherwise, a matching wb0 write this cycle returns wb0_data.
  3. Otherwise, a matching wb1 write returns wb1_data.
  4. Otherwise, the stored value is returned.
- Scoreboard, next-state per register r on the clk edge:
  - busy[r] is set if issue_en and issue_addr==r.
  - Else it is cleared if wb1_en and wb1_addr==r.
  - Else it holds.
  - Set wins over a simultaneous clear: a new load reissued to the same destination stays pending.
  - wb0 never touches busy bits.
- Hazard output:
  - rbusy[i] = busy[raddr_i] AND NOT (wb1_en AND wb1_addr==raddr_i). A completing load is bypassed, so it does not stall.
  - rbusy[i] = 0 for address 0 when ZERO_REG=1.
- Register 0 (ZERO_REG=1): writes from either port are dropped, and issue to register 0 never sets busy.
- wb1_en to a register whose busy bit is 0 is legal. The data is written and the busy bit stays 0.
- issue to a register that is already busy is legal. The busy bit stays 1 and one wb1 clears it; the decode stage guarantees ordering.
- Reset asserted mid-operation clears storage and scoreboard immediately, regardless of clk.
- Out-of-range conditions cannot occur because NREG is a power of two.
- Implementation is pure behavioural arrays plus a busy vector. No latches, no X on rdata after reset.

Test Plan:
1. Reset then read: rst pulse, raddr ports = 5 and 31 → rdata=0 on both, rbusy=0, any_busy=0.
2. Write, bypass, then stored read:
   - Cycle n: wb0_en, addr 3, data 0x1234_5678, raddr0=3 → rdata0=0x1234_5678 in the same cycle (bypass).
   - Cycle n+1: wb0_en=0 → rdata0=0x1234_5678 (stored).
3. Same-address collision: wb0 and wb1 both write addr 7 with 0xAAAA_AAAA and 0x5555_5555 → next cycle reg7=0xAAAA_AAAA.
4. Scoreboard stall and release:
   - issue_en addr 9, then raddr1=9 → rbusy[1]=1, any_busy=1.
   - 3 cycles later, wb1 addr 9 data 0xDEAD_BEEF → that cycle rbusy[1]=0 and rdata1=0xDEAD_BEEF.
   - Next cycle busy[9]=0.
5. Set-wins and zero register:
   - busy[4]=1; same cycle issue_en addr 4 and wb1_en addr 4 → busy[4] stays 1 and reg4 holds the wb1 data.
   - issue_en addr 0 and wb0 write addr 0 of 0xFFFF_FFFF → reg0 reads 0 and rbusy stays 0.
6. Asynchronous reset mid-operation with NREAD=3 configuration:
   - Fill regs 1..3 and set busy[2].
   - Assert rst between clock edges → rdata all 0 and any_busy=0 immediately.
